// File: rtl/score_keeper.sv
// Point scoring and game sequencing for a two-player paddle game: detects goal-line
// misses, keeps both scores, spaces re-serves with a hold delay and declares the winner.
module score_keeper #(
    parameter int unsigned MAX_H       = 320,
    parameter int unsigned MIN_H       = 0,
    parameter int unsigned WIN_SCORE   = 7,
    parameter int unsigned HOLD_CYCLES = 60
) (
    input  logic       clock_i,
    input  logic       reset_ni,
    input  logic       start_i,
    input  logic [8:0] ball_h_i,
    input  logic [8:0] ball_y_i,
    input  logic [8:0] player1_paddle_i,
    input  logic [8:0] player2_paddle_i,
    output logic [3:0] score1_o,
    output logic [3:0] score2_o,
    output logic       serve_o,
    output logic       point_p1_o,
    output logic       point_p2_o,
    output logic       game_over_o,
    output logic [1:0] winner_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_HOLD,
        S_OVER
    } state_e;

    localparam logic [8:0]  MIN_POS   = MIN_H[8:0];
    localparam logic [8:0]  MAX_POS   = MAX_H[8:0];
    localparam logic [3:0]  WIN       = WIN_SCORE[3:0];
    localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  score1_q, score1_d;
    logic [3:0]  score2_q, score2_d;
    logic        serve_q, serve_d;
    logic        point_p1_q, point_p1_d;
    logic        point_p2_q, point_p2_d;
    logic        game_over_q, game_over_d;
    logic [1:0]  winner_q, winner_d;
    logic [15:0] hold_q, hold_d;
    logic        miss_left, miss_right;

    // A ball sitting exactly on the paddle position is a hit.
    assign miss_left  = (ball_h_i == MIN_POS) && (ball_y_i != player1_paddle_i);
    assign miss_right = (ball_h_i == MAX_POS) && (ball_y_i != player2_paddle_i);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d     = state_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        serve_d     = 1'b0;
        point_p1_d  = 1'b0;
        point_p2_d  = 1'b0;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        hold_d      = hold_q;

        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start_i) begin
                    score1_d    = 4'd0;
                    score2_d    = 4'd0;
                    winner_d    = 2'b00;
                    game_over_d = 1'b0;
                    serve_d     = 1'b1;
                    state_d     = S_PLAY;
                end
            end
            S_PLAY: begin
                // The cycle carrying the serve pulse still shows the pre-serve ball position.
                if (!serve_q && (miss_left || miss_right)) begin
                    if (miss_left) begin
                        score2_d   = 4'(score2_q + 4'd1);
                        point_p2_d = 1'b1;
                    end else begin
                        score1_d   = 4'(score1_q + 4'd1);
                        point_p1_d = 1'b1;
                    end
                    if (score1_d == WIN || score2_d == WIN) begin
                        state_d     = S_OVER;
                        game_over_d = 1'b1;
                        winner_d    = (score1_d == WIN) ? 2'b01 : 2'b10;
                    end else begin
                        state_d = S_HOLD;
                        hold_d  = HOLD_INIT;
                    end
                end
            end
            S_HOLD: begin
                if (hold_q == 16'd0) begin
                    serve_d = 1'b1;
                    state_d = S_PLAY;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            score1_q    <= 4'd0;
            score2_q    <= 4'd0;
            serve_q     <= 1'b0;
            point_p1_q  <= 1'b0;
            point_p2_q  <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 2'b00;
            hold_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            serve_q     <= serve_d;
            point_p1_q  <= point_p1_d;
            point_p2_q  <= point_p2_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            hold_q      <= hold_d;
        end
    end

    assign score1_o    = score1_q;
    assign score2_o    = score2_q;
    assign serve_o     = serve_q;
    assign point_p1_o  = point_p1_q;
    assign point_p2_o  = point_p2_q;
    assign game_over_o = game_over_q;
    assign winner_o    = winner_q;

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter MAX_H, default 320, right-edge horizontal position (player 2 goal line); MIN_H < MAX_H SHALL hold.
REQ-002 Parameter MIN_H, default 0, left-edge horizontal position (player 1 goal line).
REQ-003 Parameter WIN_SCORE, default 7, points that end a game; range 1..15.
REQ-004 Parameter HOLD_CYCLES, default 60, cycles between a scored point and the re-serve; range 1..65535.
REQ-005 clock  input  1  single clock; all state SHALL update on its rising edge only.
REQ-006 reset  input  1  synchronous, active-low reset; sampled on the clock rising edge.
REQ-007 start  input  1  active-high request to begin a game; acted on only in IDLE or OVER.
REQ-008 ball_h  input  9  ball horizontal position from the ball stage.
REQ-009 ball_y  input  9  ball vertical position from the ball stage.
REQ-010 player1_paddle  input  9  player 1 paddle vertical position.
REQ-011 player2_paddle  input  9  player 2 paddle vertical position.
REQ-012 score1  output  4  player 1 points, registered.
REQ-013 score2  output  4  player 2 points, registered.
REQ-014 serve  output  1  one-cycle active-high pulse; drives the ball stage's active-high reset to re-centre the ball.
REQ-015 point_p1 / point_p2  output  1 each  one-cycle pulse when the respective player scores.
REQ-016 game_over  output  1  high while in OVER.
REQ-017 winner  output  2  00 none, 01 player 1, 10 player 2; 11 SHALL never occur.

Function
REQ-018 FSM states SHALL be IDLE, PLAY, HOLD, OVER; all outputs SHALL be registered.
REQ-019 Left miss (PLAY only): ball_h == MIN_H and ball_y != player1_paddle -> player 2 scores.
REQ-020 Right miss (PLAY only): ball_h == MAX_H and ball_y != player2_paddle -> player 1 scores.
REQ-021 Exact equality to the paddle position SHALL count as a hit; no point is awarded.
REQ-022 Miss detection SHALL be suppressed in IDLE, HOLD and OVER, and in any cycle where serve is high.
REQ-023 Both misses in one cycle are impossible since MIN_H < MAX_H; no arbitration is required.
REQ-024 IDLE: start=1 -> serve=1 for the next cycle, state PLAY; start=0 -> remain in IDLE.
REQ-025 Miss sampled at edge k: after edge k the scorer's score increments by 1 and its point_pX is high for exactly one cycle.
REQ-026 After edge k, if the new score == WIN_SCORE: state OVER, game_over=1, winner set; otherwise state HOLD with hold counter = HOLD_CYCLES-1.
REQ-027 HOLD: counter == 0 -> serve=1 for one cycle and state PLAY; otherwise counter decrements.
REQ-028 A point at edge k SHALL produce serve high after edge k+HOLD_CYCLES.
REQ-029 OVER: scores, winner and game_over SHALL be held until start=1.
REQ-030 OVER with start=1: clear scores, winner=00, game_over=0, serve pulse, state PLAY, all after the same edge.
REQ-031 start in PLAY or HOLD SHALL be ignored.
REQ-032 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-033 Hold counter SHALL be 16 bits wide.

Reset
REQ-034 reset=0 at an edge: state IDLE, score1=score2=0, serve=0, point_p1=point_p2=0, game_over=0, winner=00, counter=0.
REQ-035 Reset SHALL take priority over every other input and apply from any state, including mid-HOLD and during a serve pulse.

Verification (WIN_SCORE=7, HOLD_CYCLES=4 unless noted)
REQ-036 Scenario 1, reset then start: reset low 2 cycles, then start pulse -> serve high exactly 1 cycle, state PLAY, scores 0/0.
REQ-037 Scenario 2, left miss: ball_h=0, ball_y=100, player1_paddle=50 at edge k -> score2=1 and point_p2=1 after edge k; serve high after edge k+4 only.
REQ-038 Scenario 3, hits: ball_h=0, ball_y=player1_paddle=80, then ball_h=320, ball_y=player2_paddle=30 -> no score change, no point pulses, no serve.
REQ-039 Scenario 4, win: player 1 scores 7 right misses -> after the 7th, score1=7, game_over=1, winner=01, no serve; further misses and start-less cycles change nothing.
REQ-040 Scenario 5, restart from OVER: start=1 in OVER -> scores 0/0, winner=00, game_over=0, serve pulse, PLAY.
REQ-041 Scenario 6, reset mid-HOLD: reset=0 with counter=2 -> IDLE and all outputs at reset values after that edge; start pulse alone in HOLD -> ignored.
